// File: rtl/conv2_window_feeder_if.sv
// conv2_window_feeder_if
//   Bundles the sample stream (s_*), the window stream (win*) and the status
//   strobes between the layer-1/pool stage, the window feeder and the
//   conv-layer-2 datapath.
//   Modports:
//     master : the window feeder itself. It takes samples in and drives windows out.
//     slave  : the environment around it. It supplies samples and consumes windows.
//   Signals:
//     s_valid/s_ready/s_data/s_last : one CH x 8-bit sample per beat, s_last ends a record
//     win1..win4                    : per-channel TAPS-long windows, entry 0 oldest
//     win_valid/win_ready/win_last  : window handshake, win_last marks the final window
//     win_idx                       : window number within the record
//     en                            : win_valid && win_ready, datapath enable
//     short_err                     : one-cycle pulse for a record too short to window
interface conv2_window_feeder_if #(
  parameter int TAPS  = 5,
  parameter int CH    = 4,
  parameter int IDX_W = 8
);
  logic                          s_valid;
  logic                          s_ready;
  logic [CH*8-1:0]               s_data;
  logic                          s_last;
  logic signed [TAPS-1:0][7:0]   win1;
  logic signed [TAPS-1:0][7:0]   win2;
  logic signed [TAPS-1:0][7:0]   win3;
  logic signed [TAPS-1:0][7:0]   win4;
  logic                          win_valid;
  logic                          win_ready;
  logic                          win_last;
  logic [IDX_W-1:0]              win_idx;
  logic                          en;
  logic                          short_err;

  modport master (
    input  s_valid, s_data, s_last, win_ready,
    output s_ready, win1, win2, win3, win4, win_valid, win_last, win_idx, en, short_err
  );

  modport slave (
    output s_valid, s_data, s_last, win_ready,
    input  s_ready, win1, win2, win3, win4, win_valid, win_last, win_idx, en, short_err
  );
endinterface

// File: rtl/conv2_window_feeder.sv
// conv2_window_feeder
//   Streaming window generator for the second convolution layer. The block
//   accepts one CH-channel 8-bit sample per beat and keeps a TAPS-deep shift
//   window per channel. It presents the full window set with a valid/ready
//   handshake. Window state never crosses a record boundary, which s_last marks.
//   Ports:
//     clk : clock, all state changes on the rising edge
//     rst : synchronous active-low reset
//     bus : conv2_window_feeder_if.master (sample in, windows out, en, short_err)
//   Build option:
//     CONV2_ZERO_PAD_EN : "same" padding. The block presets 2 leading zeros and
//                         flushes 2 trailing zeros, so N samples yield N windows.
//                         When undefined the block does "valid" convolution and
//                         N samples yield N-TAPS+1 windows.
module conv2_window_feeder #(
  parameter int TAPS  = 5,
  parameter int CH    = 4,
  parameter int IDX_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  conv2_window_feeder_if.master bus
);

  localparam logic [1:0] FILL  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
`ifdef CONV2_ZERO_PAD_EN
  localparam logic [1:0] FLUSH = 2'd2;
  localparam int         PAD   = (TAPS - 1) / 2;
  localparam int         FIRST = TAPS - PAD;
`else
  localparam int         FIRST = TAPS;
`endif

  logic [1:0]                    state_reg;
  logic [IDX_W-1:0]              fill_cnt_reg;
  logic [CH-1:0][TAPS-1:0][7:0]  win_reg;
  logic                          win_valid_reg;
  logic                          win_last_reg;
  logic [IDX_W-1:0]              win_idx_reg;
  logic                          short_err_reg;
`ifdef CONV2_ZERO_PAD_EN
  logic [1:0]                    pad_cnt_reg;
  logic                          flush_emit;
  logic                          last_zero;
`endif

  logic                          slot_free;
  logic                          in_flush;
  logic                          s_ready_int;
  logic                          acc;
  logic                          en_int;
  logic                          completes;
  logic                          shift_en;
  logic [IDX_W-1:0]              fill_inc;
  logic [IDX_W-1:0]              idx_inc;
  logic [CH-1:0][7:0]            shift_byte;

  always_comb begin
    slot_free   = !win_valid_reg || bus.win_ready;
`ifdef CONV2_ZERO_PAD_EN
    in_flush    = (state_reg == FLUSH);
`else
    in_flush    = 1'b0;
`endif
    s_ready_int = rst && !in_flush && slot_free;
    acc         = bus.s_valid && s_ready_int;
    en_int      = win_valid_reg && bus.win_ready;
    // The sample that fills the last empty slot completes the first window.
    completes   = (fill_cnt_reg == IDX_W'(FIRST - 1));
    // A flush step shifts one zero into each channel when the output slot is free.
    shift_en    = acc || (in_flush && slot_free);
    fill_inc    = (&fill_cnt_reg) ? fill_cnt_reg : fill_cnt_reg + 1'b1;
    idx_inc     = (&win_idx_reg)  ? win_idx_reg  : win_idx_reg + 1'b1;
  end

`ifdef CONV2_ZERO_PAD_EN
  always_comb begin
    // Every shift after the first FIRST-1 shifts of a record completes a window.
    // For short records the first zero shifts may still fall below that count.
    flush_emit = (int'(fill_cnt_reg) + int'(pad_cnt_reg) + 1) >= FIRST;
    // The trailing pad is exactly PAD zeros, and the last one always emits.
    last_zero  = (pad_cnt_reg == 2'(PAD - 1));
  end
`endif

  genvar gi;
  generate
    for (gi = 0; gi < CH; gi++) begin : g_shift_in
      assign shift_byte[gi] = in_flush ? 8'd0 : bus.s_data[8*gi +: 8];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= FILL;
      fill_cnt_reg  <= '0;
      win_reg       <= '0;
      win_valid_reg <= 1'b0;
      win_last_reg  <= 1'b0;
      win_idx_reg   <= '0;
      short_err_reg <= 1'b0;
`ifdef CONV2_ZERO_PAD_EN
      pad_cnt_reg   <= '0;
`endif
    end else begin
      short_err_reg <= 1'b0;

      // A consumed window frees the slot. A load later in this block may refill it.
      if (en_int) begin
        win_valid_reg <= 1'b0;
        win_last_reg  <= 1'b0;
        win_idx_reg   <= win_last_reg ? '0 : idx_inc;
      end

      // New sample enters at TAPS-1 and the oldest entry (0) drops out.
      if (shift_en) begin
        for (int c = 0; c < CH; c++) begin
          win_reg[c] <= {shift_byte[c], win_reg[c][TAPS-1:1]};
        end
      end

      case (state_reg)
        FILL: begin
          if (acc) begin
            fill_cnt_reg <= fill_inc;
            if (completes) begin
              win_valid_reg <= 1'b1;
`ifdef CONV2_ZERO_PAD_EN
              state_reg     <= bus.s_last ? FLUSH : RUN;
`else
              // A record of exactly TAPS samples gives a window that is first and last.
              win_last_reg  <= bus.s_last;
              if (bus.s_last) begin
                fill_cnt_reg <= '0;
              end else begin
                state_reg    <= RUN;
              end
`endif
            end else if (bus.s_last) begin
`ifdef CONV2_ZERO_PAD_EN
              state_reg     <= FLUSH;
`else
              // Record too short for any window. Drop the partial window.
              short_err_reg <= 1'b1;
              fill_cnt_reg  <= '0;
              win_reg       <= '0;
`endif
            end
          end
        end

        RUN: begin
          if (acc) begin
            fill_cnt_reg  <= fill_inc;
            win_valid_reg <= 1'b1;
            if (bus.s_last) begin
`ifdef CONV2_ZERO_PAD_EN
              state_reg    <= FLUSH;
`else
              win_last_reg <= 1'b1;
              state_reg    <= FILL;
              fill_cnt_reg <= '0;
`endif
            end
          end
        end

`ifdef CONV2_ZERO_PAD_EN
        FLUSH: begin
          if (slot_free) begin
            pad_cnt_reg <= pad_cnt_reg + 1'b1;
            if (flush_emit) begin
              win_valid_reg <= 1'b1;
            end
            // The trailing zeros also preset entries 0..PAD-1 for the next record.
            if (last_zero) begin
              win_last_reg <= 1'b1;
              state_reg    <= FILL;
              fill_cnt_reg <= '0;
              pad_cnt_reg  <= '0;
            end
          end
        end
`endif

        default: state_reg <= FILL;
      endcase
    end
  end

  assign bus.s_ready   = s_ready_int;
  assign bus.en        = en_int;
  assign bus.win_valid = win_valid_reg;
  assign bus.win_last  = win_last_reg;
  assign bus.win_idx   = win_idx_reg;
  assign bus.short_err = short_err_reg;
  assign bus.win1      = win_reg[0];
  assign bus.win2      = win_reg[1];
  assign bus.win3      = win_reg[2];
  assign bus.win4      = win_reg[3];

endmodule

// File: tb/tb_conv2_window_feeder.sv
// tb_conv2_window_feeder
//   Drives directed and $urandom records into conv2_window_feeder.
//   It checks every window handshake against a record-level reference model.
//   For each record the model builds the padded sample sequence and slices every
//   TAPS-long window out of it. It also checks the handshake rules (en,
//   latency, stall hold, s_ready) and the reset values.
//   The model follows the DUT build: define CONV2_ZERO_PAD_EN for both.
module tb_conv2_window_feeder;
  localparam int TAPS  = 5;
  localparam int CH    = 4;
  localparam int IDX_W = 8;
`ifdef CONV2_ZERO_PAD_EN
  localparam bit PAD_ON = 1'b1;
`else
  localparam bit PAD_ON = 1'b0;
`endif
  localparam int PADN  = PAD_ON ? (TAPS - 1) / 2 : 0;
  localparam int FIRST = TAPS - PADN;

  typedef struct {
    logic [CH*8-1:0] data;
    bit              last;
    bit              gen;     // accepting this sample completes a window
  } samp_t;

  typedef struct {
    logic [CH*TAPS*8-1:0] w;
    bit                   last;
    int                   idx;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  conv2_window_feeder_if #(.TAPS(TAPS), .CH(CH), .IDX_W(IDX_W)) bus ();

  conv2_window_feeder #(.TAPS(TAPS), .CH(CH), .IDX_W(IDX_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  samp_t stream[$];
  exp_t  exp_q[$];
  int    checks = 0;
  int    failures = 0;
  int    exp_short = 0;
  int    obs_short = 0;
  int    hs_cnt = 0;
  int    ready_mode = 0;   // 0 always ready, 1 random, 2 stall at win_idx==1
  int    valid_pct = 100;
  int    stall_left = 0;
  bit    exp_valid_next = 1'b0;
  bit    prev_stall = 1'b0;
  logic [CH*TAPS*8-1:0] prev_w;
  logic [IDX_W-1:0]     prev_idx;
  logic                 prev_last;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // kind 0: ch0 = base+i and the other channels = -(base+i). kind 1: random bytes.
  // Only the first max_win windows are expected (used when a reset cuts the record).
  task automatic gen_record(input int n, input int kind, input int base, input int max_win);
    logic [7:0] x [CH][0:31];
    logic [7:0] p [CH][0:39];
    int         nwin;
    samp_t      s;
    exp_t       e;
    for (int i = 0; i < n; i++) begin
      for (int c = 0; c < CH; c++) begin
        if (kind == 0) x[c][i] = (c == 0) ? 8'(base + i) : 8'(-(base + i));
        else           x[c][i] = 8'($urandom_range(0, 255));
      end
      s.data = {x[3][i], x[2][i], x[1][i], x[0][i]};
      s.last = (i == n - 1);
      s.gen  = (i >= FIRST - 1);
      stream.push_back(s);
    end
    for (int c = 0; c < CH; c++) begin
      for (int j = 0; j < n + 2*PADN; j++) begin
        p[c][j] = (j < PADN || j >= n + PADN) ? 8'd0 : x[c][j - PADN];
      end
    end
    nwin = n + 2*PADN - TAPS + 1;
    if (nwin <= 0) begin
      nwin = 0;
      exp_short++;
    end
    for (int k = 0; k < nwin && k < max_win; k++) begin
      for (int c = 0; c < CH; c++) begin
        for (int i = 0; i < TAPS; i++) begin
          e.w[(c*TAPS + i)*8 +: 8] = p[c][k + i];
        end
      end
      e.last = (k == nwin - 1);
      e.idx  = k;
      exp_q.push_back(e);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_valid"}, bus.win_valid, 0);
    chk({tag, "_last"},  bus.win_last, 0);
    chk({tag, "_idx"},   bus.win_idx, 0);
    chk({tag, "_serr"},  bus.short_err, 0);
    chk({tag, "_w1"},    {24'b0, bus.win1}, 0);
    chk({tag, "_w4"},    {24'b0, bus.win4}, 0);
  endtask

  task automatic step();
    bit                   acc;
    exp_t                 e;
    samp_t                s;
    logic [CH*TAPS*8-1:0] obs;
    @(negedge clk);
    case (ready_mode)
      0: bus.win_ready = 1'b1;
      1: bus.win_ready = ($urandom_range(0, 99) < 65);
      default: begin
        if (bus.win_valid && bus.win_idx == 1 && stall_left > 0) begin
          bus.win_ready = 1'b0;
          stall_left--;
        end else begin
          bus.win_ready = 1'b1;
        end
      end
    endcase
    #1;
    obs = {bus.win4, bus.win3, bus.win2, bus.win1};
    chk("en_rule", bus.en, bus.win_valid && bus.win_ready);
    if (exp_valid_next) chk("latency", bus.win_valid, 1);
    if (prev_stall) begin
      chk("hold_win", {24'b0, obs[39:0]} ^ {24'b0, obs[159:120]},
          {24'b0, prev_w[39:0]} ^ {24'b0, prev_w[159:120]});
      chk("hold_w2", {24'b0, obs[79:40]}, {24'b0, prev_w[79:40]});
      chk("hold_idx", bus.win_idx, prev_idx);
      chk("hold_last", bus.win_last, prev_last);
    end
    if (bus.win_valid && !bus.win_ready) chk("stall_sready", bus.s_ready, 0);
    if (bus.short_err) obs_short++;
    if (bus.en) begin
      hs_cnt++;
      $display("win idx=%0d last=%0b w1=%h w2=%h w3=%h w4=%h",
               bus.win_idx, bus.win_last, bus.win1, bus.win2, bus.win3, bus.win4);
      if (exp_q.size() == 0) begin
        chk("win_expected", 64'(exp_q.size()), 1);
      end else begin
        e = exp_q.pop_front();
        chk("win1", {24'b0, obs[39:0]},    {24'b0, e.w[39:0]});
        chk("win2", {24'b0, obs[79:40]},   {24'b0, e.w[79:40]});
        chk("win3", {24'b0, obs[119:80]},  {24'b0, e.w[119:80]});
        chk("win4", {24'b0, obs[159:120]}, {24'b0, e.w[159:120]});
        chk("win_last", bus.win_last, e.last);
        chk("win_idx", bus.win_idx, 64'(e.idx));
      end
    end
    acc            = bus.s_valid && bus.s_ready;
    exp_valid_next = acc && (stream.size() > 0) && stream[0].gen;
    prev_stall     = bus.win_valid && !bus.win_ready;
    prev_w         = obs;
    prev_idx       = bus.win_idx;
    prev_last      = bus.win_last;
    @(posedge clk);
    #1;
    if (acc && stream.size() > 0) stream.delete(0);
    if (stream.size() > 0 && $urandom_range(0, 99) < valid_pct) begin
      s = stream[0];
      bus.s_valid = 1'b1;
      bus.s_data  = s.data;
      bus.s_last  = s.last;
    end else begin
      bus.s_valid = 1'b0;
      bus.s_data  = $urandom;
      bus.s_last  = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic run_idle(input int budget);
    int n = 0;
    while ((stream.size() > 0 || exp_q.size() > 0) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) begin
      chk("drain_left", 64'(stream.size() + exp_q.size()), 0);
      stream.delete();
      exp_q.delete();
    end
    repeat (4) step();
  endtask

  initial begin
    int n;
    rst = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data = '0;
    bus.s_last = 1'b0;
    bus.win_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_sready", bus.s_ready, 0);
    check_reset_vals("reset");
    @(posedge clk);
    #1;
    rst = 1'b1;

    // 8-sample ramp, consumer always ready
    ready_mode = 0;
    valid_pct = 100;
    gen_record(8, 0, 1, 99);
    run_idle(200);

    // same stream with a 3-cycle stall on window 1
    ready_mode = 2;
    stall_left = 3;
    hs_cnt = 0;
    gen_record(8, 0, 1, 99);
    run_idle(200);
    chk("stall_used", 64'(stall_left), 0);
    chk("en_pulses", 64'(hs_cnt), PAD_ON ? 8 : 4);

    // short record followed by a record of exactly TAPS samples
    ready_mode = 0;
    gen_record(3, 0, 1, 99);
    gen_record(5, 0, 10, 99);
    run_idle(200);

    // 6-sample record, then a 1-sample record of -7
    gen_record(6, 0, 1, 99);
    run_idle(200);
    gen_record(1, 0, -7, 99);
    run_idle(200);

    // reset after the 2nd window of a 10-sample record
    gen_record(10, 0, 1, 2);
    hs_cnt = 0;
    n = 0;
    while (hs_cnt < 2 && n < 200) begin
      step();
      n++;
    end
    chk("rst_hs", 64'(hs_cnt), 2);
    rst = 1'b0;
    bus.s_valid = 1'b0;
    stream.delete();
    exp_q.delete();
    @(negedge clk);
    #1;
    chk("midrst_sready", bus.s_ready, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    #1;
    check_reset_vals("midrst");
    exp_valid_next = 1'b0;
    prev_stall = 1'b0;
    gen_record(5, 0, 20, 99);
    run_idle(200);

    // random records with random valid gaps and consumer back-pressure
    ready_mode = 1;
    valid_pct = 70;
    for (int r = 0; r < 40; r++) begin
      gen_record($urandom_range(1, 12), 1, 0, 99);
    end
    run_idle(6000);

    chk("short_count", 64'(obs_short), 64'(exp_short));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/conv2_window_feeder.md
# conv2_window_feeder

Streaming window generator that drives the second convolution layer's four 5-tap inputs. Accepts one 4-channel 8-bit sample per beat from the layer-1/pool stage, keeps a 5-deep shift window per channel, and presents the full window set to the conv-layer-2 datapath with a valid/ready handshake and an `en` strobe. Records are delimited by `s_last`; window state never carries across records.

## Interface
- `TAPS`, 5: window length per channel; fixed by the layer-2 filters.
- `CH`, 4: input channels; each channel gets its own `winN` output.
- `IDX_W`, 8: width of `win_idx`.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset; synchronous, active-low.
- `s_valid`  in  1  input sample valid.
- `s_ready`  out  1  input sample accepted when `s_valid && s_ready`.
- `s_data`  in  CH*8  signed samples; channel c is `s_data[8c+7:8c]`.
- `s_last`  in  1  marks the final sample of a record.
- `win1`..`win4`  out  [TAPS-1:0][7:0] signed  per-channel windows; index 0 is the oldest sample.
- `win_valid`  out  1  window set valid.
- `win_ready`  in  1  consumer accepts the window set.
- `win_last`  out  1  final window of the record; qualified by `win_valid`.
- `win_idx`  out  IDX_W  window number within the record, starting at 0.
- `en`  out  1  equals `win_valid && win_ready`; drives the conv datapath enable.
- `short_err`  out  1  one-cycle pulse when a record is too short to produce any window.

## Operation
- Per channel, an accepted sample shifts into `TAPS-1`; all entries move down one and entry 0 is dropped.
- Counters:
  - `fill_cnt` counts accepted samples in the current record.
  - `out_cnt` counts emitted windows.
- FSM states:
  - **FILL**: accept samples. When the shift would complete a window, go to RUN and load the window.
  - **RUN**: each accepted sample produces one new window.
  - **FLUSH**: pad build only; no input accepted.
- Transitions:
  - `s_last` accepted in RUN: without pad, the last window gets `win_last` and the FSM returns to FILL. With pad, go to FLUSH.
  - `s_last` accepted in FILL (no pad, fewer than TAPS samples): pulse `short_err`, clear the window, stay in FILL, emit no windows.
- Window count per record of N samples: N-TAPS+1 without pad, N with pad.
- `win_idx` increments on each `en` and clears after the `win_last` handshake.
- `s_ready = rst && state!=FLUSH && (!win_valid || win_ready)`. A new window may load in the same cycle the old one is consumed.
- Data is passed through unmodified. There is no arithmetic beyond counters, and counters saturate at their width.

## Timing
- Reset values: `win*`=0, `win_valid`=0, `win_last`=0, `win_idx`=0, `short_err`=0, state FILL, counters 0.
- While `rst` is low, `s_ready` is 0.
- Latency: a window becomes valid one cycle after the sample that completes it is accepted.
- Throughput: one window per cycle while `win_ready` is held high.
- Stall: while `win_valid && !win_ready`, every `win*`, `win_last` and `win_idx` output holds stable and `s_ready` is 0.
- Reset mid-record drops the partial window and any in-flight window. Output is valid again one cycle after the first completing sample following reset.
- `s_last` together with the completing sample: that window is both the first and the last, with `win_idx`=0.

## Configuration
- `CONV2_ZERO_PAD_EN` defined ("same" padding):
  - At record start, window entries 0..1 are preset to 0. The first window is therefore [0,0,x0,x1,x2], valid after 3 samples.
  - After `s_last`, FLUSH shifts zeros in, one per free output slot, until `out_cnt` equals N. `win_last` is asserted on the Nth window.
  - A record with N=1 yields [0,0,x0,0,0], `win_last`=1.
  - `short_err` is never asserted.
- Not defined: "valid" convolution, no FLUSH state, windows = N-TAPS+1.

## Test plan
- No pad, ch0 = 1..8 (other channels = -1..-8), `win_ready`=1 → 4 windows. First `win1` = {1,2,3,4,5}, last = {4,5,6,7,8} with `win_last`=1 and `win_idx`=3; `win2` first = {-1,-2,-3,-4,-5}.
- Same stream with `win_ready` low for 3 cycles at `win_idx`=1 → window {2,3,4,5,6} held stable, `s_ready`=0, no sample lost, `en` pulses exactly 4 times.
- No pad, 3-sample record → `short_err` pulses once, no `win_valid`. The next 5-sample record 10..14 yields {10,11,12,13,14}.
- Pad on, ch0 = 1..6 → 6 windows: {0,0,1,2,3} … {4,5,6,0,0}, `win_last` on `win_idx`=5, `s_ready`=0 during the 2 flush windows.
- `rst` low for one cycle after the 2nd window of a 10-sample record → all outputs at reset values. A fresh record 20..24 produces {20,21,22,23,24} with `win_idx`=0.
- Pad on, 1-sample record x0=-7 → single window {0,0,-7,0,0}, `win_last`=1.
